// File: rtl/hci_mem_bank_responder_if.sv
// rtl/hci_mem_bank_responder_if.sv - hci_mem bank port request/response bundle
interface hci_mem_bank_responder_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic            req;
    logic            gnt;
    logic [AW-1:0]   add;
    logic            wen;
    logic [DW/8-1:0] be;
    logic [DW-1:0]   data;
    logic [DW-1:0]   r_data;
    logic            r_valid;

    modport master (
        output req, add, wen, be, data,
        input  gnt, r_data, r_valid
    );

    modport slave (
        input  req, add, wen, be, data,
        output gnt, r_data, r_valid
    );
endinterface

// File: rtl/hci_mem_bank_responder.sv
// rtl/hci_mem_bank_responder.sv - hci_mem bank responder: byte-enabled word array, fixed-latency responses, grant stalling
// Optional statistics counters are built when HCI_MEM_RESPONDER_STATS_EN is defined.
module hci_mem_bank_responder #(
    parameter int DW           = 32,
    parameter int AW           = 32,
    parameter int AWM          = 12,
    parameter int LATENCY      = 1,
    parameter int STALL_PERIOD = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    hci_mem_bank_responder_if.slave  bus
`ifdef HCI_MEM_RESPONDER_STATS_EN
    ,
    output logic [31:0]              rd_cnt_o,
    output logic [31:0]              wr_cnt_o,
    output logic [31:0]              stall_cnt_o
`endif
);

    localparam int NBYTES = DW / 8;
    localparam int DEPTH  = 1 << AWM;

    generate
        if (STALL_PERIOD == 1 || STALL_PERIOD < 0) begin : g_bad_stall
            $fatal(1, "hci_mem_bank_responder: STALL_PERIOD must be 0 or >= 2");
        end
        if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
            $fatal(1, "hci_mem_bank_responder: LATENCY must be in 1..4");
        end
        if ((DW % 8) != 0) begin : g_bad_dw
            $fatal(1, "hci_mem_bank_responder: DW must be a multiple of 8");
        end
    endgenerate

    logic            stall_slot;
    logic            gnt;
    logic            accept;
    logic [AWM-1:0]  idx;
    logic            unused_add;

    // One grant-low slot per STALL_PERIOD cycles, independent of traffic.
    generate
        if (STALL_PERIOD >= 2) begin : g_stall
            localparam int SCW = $clog2(STALL_PERIOD);
            localparam logic [SCW-1:0] STALL_LAST = SCW'(STALL_PERIOD - 1);
            logic [SCW-1:0] stall_cnt_q;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    stall_cnt_q <= '0;
                end else if (clear_i || stall_cnt_q == STALL_LAST) begin
                    stall_cnt_q <= '0;
                end else begin
                    stall_cnt_q <= stall_cnt_q + 1'b1;
                end
            end

            assign stall_slot = (stall_cnt_q == STALL_LAST);
        end else begin : g_no_stall
            assign stall_slot = 1'b0;
        end
    endgenerate

    assign gnt        = ~clear_i & ~stall_slot;
    assign bus.gnt    = gnt;
    assign accept     = bus.req & gnt;
    assign idx        = bus.add[AWM+1:2];
    assign unused_add = ^bus.add;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (accept && !bus.wen) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (bus.be[b]) begin
                    mem[idx][8*b +: 8] <= bus.data[8*b +: 8];
                end
            end
        end
    end

    // Stage 0 captures the pre-edge array word, so reads see state before a same-edge write.
    logic [LATENCY-1:0] pipe_valid_q;
    logic [DW-1:0]      pipe_data_q [LATENCY];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipe_valid_q <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                pipe_data_q[s] <= '0;
            end
        end else if (clear_i) begin
            pipe_valid_q <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                pipe_data_q[s] <= '0;
            end
        end else begin
            pipe_valid_q[0] <= accept;
            pipe_data_q[0]  <= (accept && bus.wen) ? mem[idx] : '0;
            for (int s = 1; s < LATENCY; s++) begin
                pipe_valid_q[s] <= pipe_valid_q[s-1];
                pipe_data_q[s]  <= pipe_data_q[s-1];
            end
        end
    end

    assign bus.r_valid = pipe_valid_q[LATENCY-1];
    assign bus.r_data  = pipe_data_q[LATENCY-1];

`ifdef HCI_MEM_RESPONDER_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_cnt_o    <= '0;
            wr_cnt_o    <= '0;
            stall_cnt_o <= '0;
        end else if (clear_i) begin
            rd_cnt_o    <= '0;
            wr_cnt_o    <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (accept && bus.wen && rd_cnt_o != '1) begin
                rd_cnt_o <= rd_cnt_o + 32'd1;
            end
            if (accept && !bus.wen && wr_cnt_o != '1) begin
                wr_cnt_o <= wr_cnt_o + 32'd1;
            end
            if (bus.req && !gnt && stall_cnt_o != '1) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hci_mem_bank_responder.sv
// tb/tb_hci_mem_bank_responder.sv - scoreboard bench for hci_mem_bank_responder (three latency/stall configurations)
`timescale 1ns/1ps
module tb_hci_mem_bank_responder;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  clr = '0;
    int          sel = 0;
    logic        req = 1'b0;
    logic        wen = 1'b1;
    logic [31:0] add = '0;
    logic [3:0]  be = '0;
    logic [31:0] data = '0;

    logic [2:0]  gnt_w;
    logic [2:0]  r_valid_w;
    logic [31:0] r_data_w [3];

    exp_t        exp_q [3][$];
    logic [31:0] mdl [3][4096];
    int          resp_cnt [3];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

`ifdef HCI_MEM_RESPONDER_STATS_EN
    logic [31:0] rd_cnt [3];
    logic [31:0] wr_cnt [3];
    logic [31:0] stall_cnt [3];
`endif

    hci_mem_bank_responder_if #(.DW(32), .AW(32)) bus0 ();
    hci_mem_bank_responder_if #(.DW(32), .AW(32)) bus1 ();
    hci_mem_bank_responder_if #(.DW(32), .AW(32)) bus2 ();

    assign bus0.req = req && (sel == 0);
    assign bus1.req = req && (sel == 1);
    assign bus2.req = req && (sel == 2);
    assign bus0.add = add;  assign bus1.add = add;  assign bus2.add = add;
    assign bus0.wen = wen;  assign bus1.wen = wen;  assign bus2.wen = wen;
    assign bus0.be = be;    assign bus1.be = be;    assign bus2.be = be;
    assign bus0.data = data; assign bus1.data = data; assign bus2.data = data;

    assign gnt_w     = {bus2.gnt, bus1.gnt, bus0.gnt};
    assign r_valid_w = {bus2.r_valid, bus1.r_valid, bus0.r_valid};
    assign r_data_w[0] = bus0.r_data;
    assign r_data_w[1] = bus1.r_data;
    assign r_data_w[2] = bus2.r_data;

    hci_mem_bank_responder #(.DW(32), .AW(32), .AWM(12), .LATENCY(1), .STALL_PERIOD(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .clear_i(clr[0]), .bus(bus0)
`ifdef HCI_MEM_RESPONDER_STATS_EN
        , .rd_cnt_o(rd_cnt[0]), .wr_cnt_o(wr_cnt[0]), .stall_cnt_o(stall_cnt[0])
`endif
    );

    hci_mem_bank_responder #(.DW(32), .AW(32), .AWM(12), .LATENCY(3), .STALL_PERIOD(0)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .clear_i(clr[1]), .bus(bus1)
`ifdef HCI_MEM_RESPONDER_STATS_EN
        , .rd_cnt_o(rd_cnt[1]), .wr_cnt_o(wr_cnt[1]), .stall_cnt_o(stall_cnt[1])
`endif
    );

    hci_mem_bank_responder #(.DW(32), .AW(32), .AWM(12), .LATENCY(1), .STALL_PERIOD(4)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .clear_i(clr[2]), .bus(bus2)
`ifdef HCI_MEM_RESPONDER_STATS_EN
        , .rd_cnt_o(rd_cnt[2]), .wr_cnt_o(wr_cnt[2]), .stall_cnt_o(stall_cnt[2])
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int s);
        return (s == 1) ? 3 : 1;
    endfunction

    // Response monitor: pops the scoreboard on every r_valid and checks data and arrival cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (r_valid_w[i] === 1'b1) begin
                resp_cnt[i]++;
                if (exp_q[i].size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected dut%0d: got r_data=%h at cycle %0d, required no response", i, r_data_w[i], cyc);
                end else begin
                    e = exp_q[i].pop_front();
                    if (r_data_w[i] !== e.data || cyc != e.due) begin
                        errors++;
                        $display("FAIL resp_data dut%0d: got %h at cycle %0d, required %h at cycle %0d", i, r_data_w[i], cyc, e.data, e.due);
                    end
                end
            end else if (r_valid_w[i] !== 1'b0 || r_data_w[i] !== 32'h0) begin
                errors++;
                $display("FAIL idle_out dut%0d: got r_valid=%b r_data=%h, required 0/0", i, r_valid_w[i], r_data_w[i]);
            end
        end
    end

    task automatic issue(input int s, input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, output int waits);
        int idx;
        exp_t e;
        idx = int'(a[13:2]);
        sel = s; req = 1'b1; wen = w; add = a; be = b; data = d;
        waits = 0;
        #1;
        while (gnt_w[s] !== 1'b1 && waits < 20) begin
            @(posedge clk); @(negedge clk); #1;
            waits++;
        end
        if (gnt_w[s] !== 1'b1) begin
            checks++; errors++;
            $display("FAIL issue_timeout dut%0d: gnt=%b, required 1 within 20 cycles", s, gnt_w[s]);
        end else begin
            e.data = 32'h0;
            if (w) begin
                e.data = mdl[s][idx];
            end else begin
                for (int k = 0; k < 4; k++) if (b[k]) mdl[s][idx][8*k +: 8] = d[8*k +: 8];
            end
            e.due = cyc + lat_of(s);
            exp_q[s].push_back(e);
        end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (r_valid_w[i] !== 1'b0 || r_data_w[i] !== 32'h0) begin
                errors++;
                $display("FAIL reset_out dut%0d: got r_valid=%b r_data=%h, required 0/0", i, r_valid_w[i], r_data_w[i]);
            end
            checks++;
            if (gnt_w[i] !== 1'b1) begin
                errors++;
                $display("FAIL reset_gnt dut%0d: got %b, required 1", i, gnt_w[i]);
            end
`ifdef HCI_MEM_RESPONDER_STATS_EN
            checks++;
            if (rd_cnt[i] !== 0 || wr_cnt[i] !== 0 || stall_cnt[i] !== 0) begin
                errors++;
                $display("FAIL reset_stats dut%0d: got %0d/%0d/%0d, required 0/0/0", i, rd_cnt[i], wr_cnt[i], stall_cnt[i]);
            end
`endif
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_rw();
        int w0, w1, base;
        base = resp_cnt[0];
        issue(0, 1'b0, 32'h10, 4'hF, 32'hDEADBEEF, w0);
        issue(0, 1'b1, 32'h10, 4'h0, 32'h0, w1);
        idle(4);
        checks++;
        if (w0 != 0 || w1 != 0) begin
            errors++;
            $display("FAIL basic_gnt: got waits %0d/%0d, required 0/0", w0, w1);
        end
        checks++;
        if (resp_cnt[0] - base != 2 || exp_q[0].size() != 0) begin
            errors++;
            $display("FAIL basic_resp: got %0d responses, %0d pending, required 2/0", resp_cnt[0] - base, exp_q[0].size());
        end
    endtask

    task automatic test_byte_enable();
        int w;
        issue(0, 1'b0, 32'h20, 4'hF, 32'h11223344, w);
        issue(0, 1'b0, 32'h20, 4'b0101, 32'hAABBCCDD, w);
        issue(0, 1'b1, 32'h20, 4'h0, 32'h0, w);
        issue(0, 1'b0, 32'h20, 4'h0, 32'hFFFFFFFF, w);
        issue(0, 1'b1, 32'h20, 4'hF, 32'h0, w);
        issue(0, 1'b0, 32'h0000_4020, 4'hF, 32'h55667788, w);
        issue(0, 1'b1, 32'h20, 4'h0, 32'h0, w);
        idle(4);
        checks++;
        if (exp_q[0].size() != 0) begin
            errors++;
            $display("FAIL be_pending: got %0d outstanding, required 0", exp_q[0].size());
        end
    endtask

    task automatic test_back_to_back();
        int w, stalls, base;
        for (int k = 0; k < 4; k++) issue(1, 1'b0, 32'(k * 4), 4'hF, 32'(k + 1), w);
        idle(6);
        base = resp_cnt[1];
        stalls = 0;
        for (int k = 0; k < 4; k++) begin
            issue(1, 1'b1, 32'(k * 4), 4'h0, 32'h0, w);
            stalls += w;
        end
        idle(7);
        checks++;
        if (stalls != 0) begin
            errors++;
            $display("FAIL b2b_gnt: got %0d stall cycles, required 0", stalls);
        end
        checks++;
        if (resp_cnt[1] - base != 4 || exp_q[1].size() != 0) begin
            errors++;
            $display("FAIL b2b_resp: got %0d responses, %0d pending, required 4/0", resp_cnt[1] - base, exp_q[1].size());
        end
    endtask

    task automatic test_stall();
        int j, acc, base, w;
        logic exp_g;
        exp_t e;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) exp_q[i].delete();
        base = resp_cnt[2];
        rst = 1'b0;
        sel = 2; j = 0; acc = 0;
        for (int k = 0; k < 12; k++) begin
            req = 1'b1; wen = 1'b0; add = 32'(j * 4); be = 4'hF; data = 32'h100 + 32'(j);
            #1;
            exp_g = ((k % 4) != 3);
            checks++;
            if (gnt_w[2] !== exp_g) begin
                errors++;
                $display("FAIL stall_gnt cycle %0d: got %b, required %b", k, gnt_w[2], exp_g);
            end
            if (gnt_w[2] === 1'b1) begin
                mdl[2][j] = data;
                e.data = 32'h0;
                e.due = cyc + 1;
                exp_q[2].push_back(e);
                acc++;
                j++;
            end
            @(posedge clk); @(negedge clk);
        end
        idle(4);
        checks++;
        if (acc != 9 || resp_cnt[2] - base != 9) begin
            errors++;
            $display("FAIL stall_count: got %0d accepts %0d responses, required 9/9", acc, resp_cnt[2] - base);
        end
`ifdef HCI_MEM_RESPONDER_STATS_EN
        checks++;
        if (stall_cnt[2] !== 32'd3 || wr_cnt[2] !== 32'd9 || rd_cnt[2] !== 32'd0) begin
            errors++;
            $display("FAIL stall_stats: got stall=%0d wr=%0d rd=%0d, required 3/9/0", stall_cnt[2], wr_cnt[2], rd_cnt[2]);
        end
`endif
        issue(2, 1'b1, 32'h8, 4'h0, 32'h0, w);
        issue(2, 1'b1, 32'h20, 4'h0, 32'h0, w);
        idle(4);
        checks++;
        if (exp_q[2].size() != 0) begin
            errors++;
            $display("FAIL stall_pending: got %0d outstanding, required 0", exp_q[2].size());
        end
    endtask

    task automatic test_clear();
        int w, base;
        issue(1, 1'b1, 32'h0, 4'h0, 32'h0, w);
        issue(1, 1'b1, 32'h4, 4'h0, 32'h0, w);
        clr[1] = 1'b1;
        req = 1'b1; sel = 1; wen = 1'b0; add = 32'h0; be = 4'hF; data = 32'hFFFFFFFF;
        #1;
        checks++;
        if (gnt_w[1] !== 1'b0) begin
            errors++;
            $display("FAIL clear_gnt: got %b, required 0", gnt_w[1]);
        end
        exp_q[1].delete();
        base = resp_cnt[1];
        @(posedge clk); @(negedge clk);
        clr[1] = 1'b0;
        req = 1'b0;
`ifdef HCI_MEM_RESPONDER_STATS_EN
        #1;
        checks++;
        if (rd_cnt[1] !== 32'd0 || stall_cnt[1] !== 32'd0) begin
            errors++;
            $display("FAIL clear_stats: got rd=%0d stall=%0d, required 0/0", rd_cnt[1], stall_cnt[1]);
        end
`endif
        idle(6);
        checks++;
        if (resp_cnt[1] != base) begin
            errors++;
            $display("FAIL clear_drop: got %0d responses after clear, required 0", resp_cnt[1] - base);
        end
        issue(1, 1'b1, 32'h0, 4'h0, 32'h0, w);
        issue(1, 1'b1, 32'h4, 4'h0, 32'h0, w);
        idle(6);
        checks++;
        if (exp_q[1].size() != 0) begin
            errors++;
            $display("FAIL clear_pending: got %0d outstanding, required 0", exp_q[1].size());
        end
`ifdef HCI_MEM_RESPONDER_STATS_EN
        checks++;
        if (rd_cnt[1] !== 32'd2) begin
            errors++;
            $display("FAIL clear_rdcnt: got %0d, required 2", rd_cnt[1]);
        end
`endif
    endtask

    task automatic test_reset_midflight();
        int w, base;
        issue(0, 1'b0, 32'h40, 4'hF, 32'hCAFE0001, w);
        idle(3);
        sel = 0; req = 1'b1; wen = 1'b1; add = 32'h40; be = 4'h0;
        #1;
        checks++;
        if (gnt_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_gnt: got %b, required 1", gnt_w[0]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (r_valid_w[0] !== 1'b1 || r_data_w[0] !== 32'hCAFE0001) begin
            errors++;
            $display("FAIL rst_pre_resp: got r_valid=%b r_data=%h, required 1/cafe0001", r_valid_w[0], r_data_w[0]);
        end
        req = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (r_valid_w[0] !== 1'b0 || r_data_w[0] !== 32'h0) begin
            errors++;
            $display("FAIL rst_async: got r_valid=%b r_data=%h, required 0/0", r_valid_w[0], r_data_w[0]);
        end
        for (int i = 0; i < 3; i++) exp_q[i].delete();
        base = resp_cnt[0];
        @(negedge clk);
        rst = 1'b0;
        idle(5);
        checks++;
        if (resp_cnt[0] != base) begin
            errors++;
            $display("FAIL rst_drop: got %0d responses after reset, required 0", resp_cnt[0] - base);
        end
        issue(0, 1'b1, 32'h40, 4'h0, 32'h0, w);
        issue(0, 1'b1, 32'h10, 4'h0, 32'h0, w);
        idle(4);
        checks++;
        if (exp_q[0].size() != 0) begin
            errors++;
            $display("FAIL rst_pending: got %0d outstanding, required 0", exp_q[0].size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) resp_cnt[i] = 0;
        test_reset();
        test_basic_rw();
        test_byte_enable();
        test_back_to_back();
        test_stall();
        test_clear();
        test_reset_midflight();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (exp_q[i].size() != 0) begin
                errors++;
                $display("FAIL final_pending dut%0d: got %0d outstanding, required 0", i, exp_q[i].size());
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
